// File: rtl/seq_pkg.sv
// Shared encodings for the microprogram sequencer slice.
package seq_pkg;

  localparam logic [1:0] SEL_PC  = 2'd0;
  localparam logic [1:0] SEL_AR  = 2'd1;
  localparam logic [1:0] SEL_STK = 2'd2;
  localparam logic [1:0] SEL_DIN = 2'd3;

endpackage

// File: rtl/seq_stack.sv
// Count-based LIFO subroutine stack for the sequencer slice; illegal push/pop are ignored.
// With SEQ_SLICE_STACK_ERR_EN defined it also reports illegal operations on illegal_op.
module seq_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fe_n,
  input  logic             pup,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] tos,
  output logic             push_ok,
  output logic             full,
  output logic             empty
`ifdef SEQ_SLICE_STACK_ERR_EN
  ,
  output logic             illegal_op
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic             pop_ok;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = ~fe_n & pup & ~full;
  assign pop_ok  = ~fe_n & ~pup & ~empty;
  assign wr_idx  = AW'(count_q);
  assign rd_idx  = AW'(count_q - CW'(1));
  assign tos     = empty ? '0 : stack_q[rd_idx];

`ifdef SEQ_SLICE_STACK_ERR_EN
  assign illegal_op = ~fe_n & (pup ? full : empty);
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    stack_d = stack_q;
    if (push_ok) begin
      stack_d[wr_idx] = push_data;
      count_d         = count_q + CW'(1);
    end else if (pop_ok) begin
      // Popped entries keep their contents; only the count moves.
      count_d = count_q - CW'(1);
    end
  end

  // NOTE: the storage array is reset too, because the reset state defines every entry as zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      count_q <= count_d;
      stack_q <= stack_d;
    end
  end

endmodule

// File: rtl/seq_slice_n.sv
// Microprogram sequencer slice: next-address mux, incrementer, pc/ar registers and stack.
// Optional sticky stack error flag (err_clr / stack_err) when SEQ_SLICE_STACK_ERR_EN is defined.
module seq_slice_n
  import seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       sel,
  input  logic             zero_n,
  input  logic             cin,
  input  logic             re_n,
  input  logic             fe_n,
  input  logic             pup,
  output logic [WIDTH-1:0] yout,
  output logic             cout,
  output logic             stack_full,
  output logic             stack_empty
`ifdef SEQ_SLICE_STACK_ERR_EN
  ,
  input  logic             err_clr,
  output logic             stack_err
`endif
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ar_q, ar_d;
  logic [WIDTH-1:0] tos;
  logic             push_ok;

`ifdef SEQ_SLICE_STACK_ERR_EN
  logic illegal_op;
  logic err_q, err_d;
`endif

  seq_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .fe_n      (fe_n),
    .pup       (pup),
    .push_data (pc_q),
    .tos       (tos),
    .push_ok   (push_ok),
    .full      (stack_full),
    .empty     (stack_empty)
`ifdef SEQ_SLICE_STACK_ERR_EN
    ,
    .illegal_op(illegal_op)
`endif
  );

  always_comb begin
    yout = '0;
    if (zero_n) begin
      unique case (sel)
        SEL_PC:  yout = pc_q;
        SEL_AR:  yout = ar_q;
        // A push this cycle returns pc so a call can target itself.
        SEL_STK: yout = push_ok ? pc_q : tos;
        SEL_DIN: yout = din;
        default: yout = '0;
      endcase
    end
  end

  assign cout = cin & (&yout);

  always_comb begin
    pc_d = yout + WIDTH'(cin);
    ar_d = re_n ? ar_q : din;
  end

`ifdef SEQ_SLICE_STACK_ERR_EN
  // Set has priority over clear on the same edge.
  always_comb begin
    err_d = err_q;
    if (illegal_op)   err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  assign stack_err = err_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= '0;
      ar_q <= '0;
`ifdef SEQ_SLICE_STACK_ERR_EN
      err_q <= 1'b0;
`endif
    end else begin
      pc_q <= pc_d;
      ar_q <= ar_d;
`ifdef SEQ_SLICE_STACK_ERR_EN
      err_q <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_slice_n.sv
// Self-checking bench for seq_slice_n: directed scenarios then random traffic vs a queue-based model.
module tb_seq_slice_n;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic [1:0]       sel;
  logic             zero_n, cin, re_n, fe_n, pup;
  logic [WIDTH-1:0] yout;
  logic             cout, stack_full, stack_empty;
  logic             err_clr;
`ifdef SEQ_SLICE_STACK_ERR_EN
  logic             stack_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_pc, m_ar;
  bit m_err;
  int m_stk[$];

  always #5 clock = ~clock;

  seq_slice_n #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .din         (din),
    .sel         (sel),
    .zero_n      (zero_n),
    .cin         (cin),
    .re_n        (re_n),
    .fe_n        (fe_n),
    .pup         (pup),
    .yout        (yout),
    .cout        (cout),
    .stack_full  (stack_full),
    .stack_empty (stack_empty)
`ifdef SEQ_SLICE_STACK_ERR_EN
    ,
    .err_clr     (err_clr),
    .stack_err   (stack_err)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_yout();
    int r;
    if (!zero_n) return 0;
    case (sel)
      2'd0: r = m_pc;
      2'd1: r = m_ar;
      2'd2: begin
        if (!fe_n && pup && m_stk.size() < DEPTH) r = m_pc;
        else if (m_stk.size() == 0)               r = 0;
        else                                      r = m_stk[m_stk.size()-1];
      end
      default: r = int'(din);
    endcase
    return r;
  endfunction

  task automatic idle();
    reset = 0; din = '0; sel = 2'd0; zero_n = 1; cin = 0;
    re_n = 1; fe_n = 1; pup = 0; err_clr = 0;
  endtask

  // Called in the low phase with inputs applied; checks outputs, advances model, waits one cycle.
  task automatic step();
    int  y;
    bit  illegal;
    #1;
    y = exp_yout();
    check("yout", int'(yout), y);
    check("cout", int'(cout), (cin && y == MASK) ? 1 : 0);
    check("stack_full", int'(stack_full), (m_stk.size() == DEPTH) ? 1 : 0);
    check("stack_empty", int'(stack_empty), (m_stk.size() == 0) ? 1 : 0);
`ifdef SEQ_SLICE_STACK_ERR_EN
    check("stack_err", int'(stack_err), int'(m_err));
`endif
    if (reset) begin
      m_pc = 0; m_ar = 0; m_err = 0;
      m_stk.delete();
    end else begin
      illegal = 0;
      if (!fe_n) begin
        if (pup) begin
          if (m_stk.size() < DEPTH) m_stk.push_back(m_pc);
          else illegal = 1;
        end else begin
          if (m_stk.size() > 0) void'(m_stk.pop_back());
          else illegal = 1;
        end
      end
      if (!re_n) m_ar = int'(din);
      m_pc = (y + int'(cin)) & MASK;
      if (illegal)      m_err = 1;
      else if (err_clr) m_err = 0;
    end
    @(negedge clock);
  endtask

  initial begin
    idle();
    m_pc = 0; m_ar = 0; m_err = 0;
    @(negedge clock);

    // Reset then free-running increment with wrap
    reset = 1;
    step();
    idle();
    cin = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("inc_yout", int'(yout), i % 16);
      check("inc_cout", int'(cout), (i % 16 == 15) ? 1 : 0);
      step();
    end

    // Branch via ar, then direct din
    idle(); re_n = 0; din = 4'd9; step();
    idle(); sel = 2'd1; cin = 1; #1; check("ar_branch", int'(yout), 9); step();
    idle(); sel = 2'd0; #1; check("pc_after_ar", int'(yout), 10); step();
    idle(); sel = 2'd3; din = 4'd5; step();
    idle(); sel = 2'd0; step();
    idle(); sel = 2'd0; #1; check("pc_hold", int'(yout), 5); step();

    // Call at pc=6, then return
    idle(); sel = 2'd3; din = 4'd6; step();
    idle(); fe_n = 0; pup = 1; sel = 2'd3; din = 4'd12; #1; check("call_yout", int'(yout), 12); step();
    idle(); #1; check("call_depth", int'(stack_empty), 0); step();
    idle(); fe_n = 0; pup = 0; sel = 2'd2; cin = 1; #1; check("ret_yout", int'(yout), 6); step();
    idle(); #1; check("ret_pc", int'(yout), 7); check("ret_empty", int'(stack_empty), 1); step();

    // Overflow then underflow
    for (int i = 0; i < 5; i++) begin
      idle(); fe_n = 0; pup = 1; cin = 1; step();
    end
    idle(); #1; check("ovf_full", int'(stack_full), 1); step();
    for (int i = 0; i < 5; i++) begin
      idle(); fe_n = 0; pup = 0; cin = 1; step();
    end
    idle(); err_clr = 1; step();
    idle(); step();

    // Push bypass and zero override
    idle(); sel = 2'd3; din = 4'd3; step();
    idle(); fe_n = 0; pup = 1; sel = 2'd2; #1; check("bypass", int'(yout), 3); step();
    idle(); zero_n = 0; sel = 2'($urandom_range(3)); cin = 1; #1;
    check("zero_yout", int'(yout), 0); check("zero_cout", int'(cout), 0); step();
    idle(); #1; check("zero_pc", int'(yout), 1); step();

    // Reset colliding with push and ar load
    idle(); sel = 2'd3; din = 4'd7; step();
    idle(); reset = 1; fe_n = 0; pup = 1; re_n = 0; din = 4'd11; step();
    idle(); sel = 2'd1; #1; check("rst_ar", int'(yout), 0); check("rst_empty", int'(stack_empty), 1); step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(49) == 0);
      din     = WIDTH'($urandom);
      sel     = 2'($urandom);
      zero_n  = ($urandom_range(9) != 0);
      cin     = 1'($urandom);
      re_n    = 1'($urandom);
      fe_n    = ($urandom_range(2) == 0) ? 1'b1 : 1'b0;
      pup     = 1'($urandom);
      err_clr = ($urandom_range(7) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
